// File: rtl/seg_disp_pkg.sv
// Shared types and seven-segment helpers for the display arbiter.
// State encoding, blank pattern and nibble-to-segment mapping (active-low {g..a}).
package seg_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] NIB_BLANK = 4'hF;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dd_bin2bcd_seq.sv
// Sequential double-dabble, 8-bit binary to 3-digit BCD; latency 8 cycles after start.
// No backpressure: done is a one-cycle pulse alongside the final bcd; a new start restarts it.
module dd_bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [19:0] sh;
  logic [19:0] sh_next;
  logic [2:0]  cnt;
  logic        active;

  // One add-3 / shift step on {bcd[11:0], bin[7:0]}
  always_comb begin
    sh_next = sh;
    for (int i = 0; i < 3; i++) begin
      if (sh_next[8+4*i +: 4] >= 4'd5) begin
        sh_next[8+4*i +: 4] = sh_next[8+4*i +: 4] + 4'd3;
      end
    end
    sh_next = {sh_next[18:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= {12'd0, bin};
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      sh  <= sh_next;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        active <= 1'b0;
      end
    end
  end

  // The eighth shift is presented combinationally so the caller can capture it on that edge
  assign done = active && (cnt == 3'd7);
  assign bcd  = sh_next[19:8];

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin share of a 4-digit 7-seg display; grant -> digits visible 9 cycles later, held DWELL_CYCLES.
// req_ready only in IDLE; define SEG_ARB_OWNER_DIGIT_EN to show the owner index on digit 3.
module seg_display_arbiter #(
  parameter int N_REQ        = 3,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int REFRESH_BITS = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_value,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 busy,
  output logic [3:0]           owner,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an
);
  import seg_disp_pkg::*;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  state_t                  state;
  logic [3:0]              last_grant;
  logic [31:0]             dwell_cnt;
  logic [11:0]             disp_bcd;
  logic                    disp_blank;
  logic [REFRESH_BITS-1:0] scan;

  logic                    gnt_any;
  logic [3:0]              gnt_idx;
  logic [N_REQ-1:0]        gnt_oh;
  logic [4:0]              cand;
  logic [7:0]              sel_value;
  logic                    handshake;
  logic                    conv_done;
  logic [11:0]             conv_bcd;
  logic [1:0]              digit_sel;
  logic [3:0]              nib;

  // First valid requester searching upward from last_grant+1, wrapping at N_REQ
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = 5'(last_grant) + 5'(k);
      if (cand >= 5'(N_REQ)) begin
        cand = cand - 5'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_any && (cand == 5'(i)) && req_valid[i]) begin
          gnt_any   = 1'b1;
          gnt_idx   = 4'(i);
          gnt_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_value = req_value[8*i +: 8];
      end
    end
  end

  assign handshake = (state == IDLE) && !rst && gnt_any;
  assign req_ready = handshake ? gnt_oh : '0;

  dd_bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (handshake),
    .bin   (sel_value),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      last_grant <= 4'(N_REQ - 1);
      owner      <= '0;
      dwell_cnt  <= '0;
      disp_bcd   <= '0;
      disp_blank <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state      <= CONV;
            busy       <= 1'b1;
            last_grant <= gnt_idx;
            owner      <= gnt_idx;
          end
        end
        CONV: begin
          if (conv_done) begin
            state      <= SHOW;
            disp_bcd   <= conv_bcd;
            disp_blank <= 1'b0;
            dwell_cnt  <= '0;
          end
        end
        SHOW: begin
          if (dwell_cnt == DWELL_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dwell_cnt <= dwell_cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= '0;
    end else begin
      scan <= scan + REFRESH_BITS'(1);
    end
  end

  assign digit_sel = scan[REFRESH_BITS-1 -: 2];

  always_comb begin
    an  = 4'b1111;
    nib = NIB_BLANK;
    case (digit_sel)
      2'd0: begin an = 4'b1110; nib = disp_bcd[3:0];  end
      2'd1: begin an = 4'b1101; nib = disp_bcd[7:4];  end
      2'd2: begin an = 4'b1011; nib = disp_bcd[11:8]; end
      default: begin
        an = 4'b0111;
`ifdef SEG_ARB_OWNER_DIGIT_EN
        nib = owner;
`else
        nib = NIB_BLANK;
`endif
      end
    endcase
    seg = disp_blank ? SEG_BLANK : seg_encode(nib);
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: value-level display model checked every cycle plus directed literal checks.
module tb_seg_display_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int RB = 4;
  localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_value = '0;
  logic [N-1:0]   req_ready;
  logic           busy;
  logic [3:0]     owner;
  logic [6:0]     seg;
  logic           dp;
  logic [3:0]     an;

  seg_display_arbiter #(.N_REQ(N), .DWELL_CYCLES(DW), .REFRESH_BITS(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_value (req_value),
    .req_ready (req_ready),
    .busy      (busy),
    .owner     (owner),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: what the board should show, tracked as values and remaining busy cycles
  int m_last = N - 1, m_owner = 0, m_val = 0, m_pend = 0, m_left = 0, m_scan = 0, m_g = 0;
  bit m_blank = 1'b1, chk_en = 1'b0;

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (((req_valid >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  function automatic int exp_seg(input int d);
    if (m_blank) return BLANK;
    case (d)
      0: return PAT[m_val % 10];
      1: return PAT[(m_val / 10) % 10];
      2: return PAT[m_val / 100];
      default: begin
`ifdef SEG_ARB_OWNER_DIGIT_EN
        return PAT[m_owner];
`else
        return BLANK;
`endif
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_last = N - 1; m_owner = 0; m_left = 0; m_scan = 0; m_blank = 1'b1;
      chk_en = 1'b1;
    end else begin
      m_scan = (m_scan + 1) % (1 << RB);
      if (m_left > 0) begin
        m_left--;
        if (m_left == DW) begin
          m_val = m_pend;
          m_blank = 1'b0;
        end
      end else begin
        m_g = pick();
        if (m_g >= 0) begin
          m_last = m_g; m_owner = m_g;
          m_pend = int'((req_value >> (8 * m_g)) & 24'hFF);
          m_left = 8 + DW;
        end
      end
    end
  end

  int c_d, c_g;
  logic [N-1:0] c_er;
  always @(negedge clk) begin
    if (chk_en) begin
      c_d  = m_scan >> (RB - 2);
      c_er = '0;
      if (!rst && m_left == 0) begin
        c_g = pick();
        if (c_g >= 0) c_er = N'(1) << c_g;
      end
      chk("an",        an,        (~(1 << c_d)) & 15);
      chk("seg",       seg,       exp_seg(c_d));
      chk("dp",        dp,        1);
      chk("req_ready", req_ready, c_er);
      chk("busy",      busy,      (m_left > 0) ? 1 : 0);
      chk("owner",     owner,     m_owner);
    end
  end

  // Stimulus helpers: inputs change 2 time units after the rising edge
  int T, prev_t;
  logic [6:0] cap [4];

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int exp_idx, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      #1;
      if ((req_ready & req_valid) != 0) begin
        hit = 1'b1;
        T = cyc;
        chk({name, "_grant"}, req_ready, 1 << exp_idx);
      end
      @(posedge clk); #2;
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic capture();
    for (int d = 0; d < 4; d++) cap[d] = 7'h55;
    for (int i = 0; i < (1 << RB); i++) begin
      #1;
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: ;
      endcase
      @(posedge clk); #2;
    end
  endtask

  task automatic chk_digits(input string name, input int h, input int t, input int o, input int d3);
    chk({name, "_ones"}, cap[0], PAT[o]);
    chk({name, "_tens"}, cap[1], PAT[t]);
    chk({name, "_hund"}, cap[2], PAT[h]);
    chk({name, "_d3"},   cap[3], d3);
  endtask

  int own_d3 [3];
  int exp3 [4][3] = '{'{0, 0, 7}, '{0, 4, 2}, '{2, 0, 0}, '{0, 0, 7}};

  initial begin
`ifdef SEG_ARB_OWNER_DIGIT_EN
    own_d3 = '{PAT[0], PAT[1], PAT[2]};
`else
    own_d3 = '{BLANK, BLANK, BLANK};
`endif
    // Reset hold, then a full blank scan
    rst = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, BLANK);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b0;
    tick();
    capture();
    for (int d = 0; d < 4; d++) chk("blank_scan", cap[d], BLANK);

    // Single requester showing 255; late value change ignored
    req_value = {8'd0, 8'd0, 8'd255};
    req_valid = 3'b001;
    wait_grant(0, "t2");
    req_valid = '0;
    req_value[7:0] = 8'd17;
    #1;
    chk("t2_ready_after", req_ready, 0);
    wait_until(T + 8);
    #1;
    chk("t2_blank_t8", seg, BLANK);
    chk("t2_busy_t8", busy, 1);
    wait_until(T + 9);
    capture();
    chk_digits("t2", 2, 5, 5, own_d3[0]);
    #1;
    chk("t2_busy_t25", busy, 0);
    chk("t2_owner", owner, 0);

    // All three valid: 0,1,2,0 each 25 cycles apart
    do_reset();
    req_value = {8'd200, 8'd42, 8'd7};
    req_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_grant(g % 3, "t3");
      if (g > 0) chk("t3_gap", T - prev_t, 25);
      prev_t = T;
      if (g == 3) req_valid = '0;
      wait_until(T + 9);
      capture();
      chk_digits("t3", exp3[g][0], exp3[g][1], exp3[g][2], own_d3[g % 3]);
    end

    // Round-robin continues after requester 1
    req_value = {8'd31, 8'd64, 8'd13};
    req_valid = 3'b010;
    wait_grant(1, "t4a");
    req_valid = 3'b101;
    wait_grant(2, "t4b");
    wait_grant(0, "t4c");
    req_valid = '0;
    wait_until(T + 9);
    #1;
    chk("t4_owner", owner, 0);

    // Reset during conversion of 99
    wait_until(T + 25);
    req_value[15:8] = 8'd99;
    req_valid = 3'b010;
    wait_grant(1, "t5");
    req_valid = '0;
    wait_until(T + 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_seg", seg, BLANK);
    chk("t5_ready", req_ready, 0);
    req_valid = 3'b111;
    wait_grant(0, "t5_after");
    req_valid = '0;

    // Requester 2 showing 123; digit 3 depends on build option
    wait_until(T + 25);
    req_value[23:16] = 8'd123;
    req_valid = 3'b100;
    wait_grant(2, "t6");
    req_valid = '0;
    wait_until(T + 9);
    capture();
    chk_digits("t6", 1, 2, 3, own_d3[2]);

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's 4-digit multiplexed seven-segment display among N_REQ requesters that each want to show an 8-bit unsigned value. It grants requesters round-robin over a valid/ready handshake, converts the granted value to BCD with a sequential double-dabble engine, and holds it on the display for a fixed dwell period. It also scans the anodes and drives the segment outputs directly. It replaces a single-source display path at the board top level.

## Interface
- N_REQ, 3: number of requesters; legal range 1..10.
- DWELL_CYCLES, 50_000_000: cycles a granted value stays displayed; minimum 1.
- REFRESH_BITS, 19: width of the scan counter; bits [REFRESH_BITS-1:REFRESH_BITS-2] select the digit.
- clk  input  1  system clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  requester i has a value to show.
- req_value  input  8*N_REQ  requester i's value is in bits [8i+7:8i].
- req_ready  output  N_REQ  one-hot or zero; transfer on valid[i] & ready[i].
- busy  output  1  high in every state except IDLE.
- owner  output  4  index of the requester currently displayed; reset value 0.
- seg  output  7  active-low segments {g..a}.
- dp  output  1  active-low decimal point; always 1.
- an  output  4  active-low anodes; exactly one is low at all times.

## Operation
- FSM states: IDLE, CONV, SHOW.
- IDLE, any req_valid high:
  - The arbiter picks the first valid index searching from last_grant+1, modulo N_REQ.
  - req_ready for that index is high combinationally in the same cycle.
  - On that edge: latch req_value, update last_grant and owner, go to CONV.
- IDLE, no req_valid: stay in IDLE; display keeps its last content.
- CONV: 8 shift cycles of double-dabble on a 20-bit {bcd[11:0], bin[7:0]} register.
  - Add 3 to any BCD nibble that is ≥5 before each shift.
  - After the 8th shift, load the display register with bcd[11:0], clear disp_blank, go to SHOW.
- SHOW: count DWELL_CYCLES cycles, then go to IDLE.
- req_ready is 0 in CONV and SHOW. A valid deasserted before it is granted is simply skipped (no penalty).
- Scan counter free-runs; digit_sel selects the anode and nibble:
  - 0: an=1110, ones.
  - 1: an=1101, tens.
  - 2: an=1011, hundreds.
  - 3: an=0111, owner digit (see Configuration).
- Segment encoding:
  - Nibbles 0–9 use the standard active-low patterns (0 → 1000000, 8 → 0000000).
  - Any other nibble, or disp_blank=1, gives 1111111.
- Reset values:
  - State IDLE, last_grant=N_REQ-1 (so requester 0 has first priority), owner=0, disp_blank=1.
  - Scan counter 0, so an=1110, seg=1111111, dp=1, req_ready=0, busy=0.

## Timing
- Handshake at cycle T.
- CONV occupies T+1..T+8; new digits are visible from T+9.
- SHOW occupies T+9..T+8+DWELL_CYCLES; IDLE at T+9+DWELL_CYCLES.
- Earliest next grant is cycle T+9+DWELL_CYCLES.
- req_value is sampled only in the handshake cycle; later changes have no effect.
- Reset asserted in any state:
  - Next cycle is IDLE with the display blank.
  - An in-flight conversion is discarded.
  - Requester priority restarts at index 0.
- Scan counter wraps from 2^REFRESH_BITS-1 to 0 without interruption. Digit changes never alter FSM timing.

## Configuration
- SEG_ARB_OWNER_DIGIT_EN defined: digit 3 shows owner (0..N_REQ-1) with the digit patterns, and is blank while disp_blank=1.
- Undefined: digit 3 is always blank (nibble forced to 4'hF); the owner port still updates.

## Structure
- Package seg_disp_pkg holds:
  - The state enum (IDLE, CONV, SHOW).
  - SEG_BLANK = 7'b1111111.
  - A function mapping a nibble to active-low seg.
- Sub-module dd_bin2bcd_seq holds the sequential double-dabble:
  - Ports: clk, rst, start, bin[7:0], done (one-cycle pulse), bcd[11:0].
  - Fixed 8-cycle latency; done accompanies the final result.
- Arbiter, dwell counter, scan counter and segment decode stay in seg_display_arbiter.

## Test plan
- All tests use N_REQ=3, DWELL_CYCLES=16, REFRESH_BITS=4.
- Reset hold 3 cycles → an=1110, seg=1111111, req_ready=000, busy=0. After release, all four digits read blank for a full scan.
- req_valid=001, value0=8'd255, handshake at T → req_ready=001 only at T. Digits 2/5/5 from T+9; busy falls at T+25; owner=0.
- req_valid=111 held, values 7/42/200 → grants in order 0,1,2,0, each 25 cycles apart. Digits 0/0/7, 0/4/2, 2/0/0 in turn.
- req_valid=010 until its grant, then 101 → next grant goes to requester 2 (round-robin after 1), then 0.
- Reset asserted at T+4 during conversion of 8'd99 → IDLE next cycle, display blank, busy=0. Next grant with valid=111 goes to requester 0.
- Build with SEG_ARB_OWNER_DIGIT_EN, grant requester 2 → an=0111 shows seg=0100100. Without the macro → 1111111.
